// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable single-clock FIFO.
// Level-to-flag decode is binary (no gray coding needed in one clock domain).
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic afull;
      logic pfull;
      logic empty;
      logic aempty;
      logic pempty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{
      full:   1'b0,
      afull:  1'b0,
      pfull:  1'b0,
      empty:  1'b1,
      aempty: 1'b0,
      pempty: 1'b1
   };

   function automatic int unsigned fifo_entries(input int unsigned depth);
      return 32'(1) << depth;
   endfunction

   // Decode a word count into the full status flag set
   function automatic fifo_flags_t flags_from_level(
      input int unsigned level,
      input int unsigned entries,
      input int unsigned pfull_th,
      input int unsigned pempty_th
   );
      fifo_flags_t f;
      f.full   = (level == entries);
      f.afull  = (level == entries - 1);
      f.pfull  = (level >= pfull_th);
      f.empty  = (level == 0);
      f.aempty = (level == 1);
      f.pempty = (level <= pempty_th);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_prog: synchronous write, asynchronous read.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [DEPTH-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int unsigned ENTRIES = fifo_entries(DEPTH);

   logic [WIDTH-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, level/remain and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read; default is registered read.
module sync_fifo_prog
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid,
   input  logic [DEPTH:0]   i_pfull_th,
   input  logic [DEPTH:0]   i_pempty_th,
   input  logic             i_err_clr,
   output logic             o_full,
   output logic             o_afull,
   output logic             o_pfull,
   output logic             o_empty,
   output logic             o_aempty,
   output logic             o_pempty,
   output logic [DEPTH:0]   o_level,
   output logic [DEPTH:0]   o_remain,
   output logic             o_ovf,
   output logic             o_udf
);

   localparam int unsigned PW      = DEPTH + 1;
   localparam int unsigned ENTRIES = fifo_entries(DEPTH);

   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW-1:0]    level_q;
   logic [PW-1:0]    level_d;
   logic [PW-1:0]    remain_q;
   fifo_flags_t      flags_q;
   fifo_flags_t      flags_d;
   logic             ovf_q;
   logic             udf_q;
   logic             push_ok;
   logic             pop_ok;
   logic [WIDTH-1:0] ram_rdata;

   // Blocking decisions use only the registered flags
   always_comb begin
      push_ok = i_wr_en & ~flags_q.full;
      pop_ok  = i_rd_en & ~flags_q.empty;
      level_d = level_q + PW'(push_ok) - PW'(pop_ok);
      flags_d = flags_from_level(32'(level_d), ENTRIES,
                                 32'(i_pfull_th), 32'(i_pempty_th));
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         remain_q <= PW'(ENTRIES);
         flags_q  <= FLAGS_RST;
      end else begin
         wptr_q   <= wptr_q + PW'(push_ok);
         rptr_q   <= rptr_q + PW'(pop_ok);
         level_q  <= level_d;
         remain_q <= PW'(ENTRIES) - level_d;
         flags_q  <= flags_d;
      end
   end

   // Sticky errors: a fresh event outranks a clear in the same cycle
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= (i_wr_en & flags_q.full)  | (ovf_q & ~i_err_clr);
         udf_q <= (i_rd_en & flags_q.empty) | (udf_q & ~i_err_clr);
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (i_clk),
      .we    (push_ok),
      .waddr (wptr_q[DEPTH-1:0]),
      .wdata (i_wr_data),
      .raddr (rptr_q[DEPTH-1:0]),
      .rdata (ram_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented as soon as the FIFO is non-empty
   assign o_rd_data  = ram_rdata;
   assign o_rd_valid = ~flags_q.empty;
`else
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (pop_ok) rd_data_q <= ram_rdata;
         rd_valid_q <= pop_ok;
      end
   end

   assign o_rd_data  = rd_data_q;
   assign o_rd_valid = rd_valid_q;
`endif

   assign o_full   = flags_q.full;
   assign o_afull  = flags_q.afull;
   assign o_pfull  = flags_q.pfull;
   assign o_empty  = flags_q.empty;
   assign o_aempty = flags_q.aempty;
   assign o_pempty = flags_q.pempty;
   assign o_level  = level_q;
   assign o_remain = remain_q;
   assign o_ovf    = ovf_q;
   assign o_udf    = udf_q;

endmodule
